// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: funct3 size codes,
// FSM state encoding and request decode helpers.
package lsu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Bytes moved by an access; 0 marks an undefined size code.
   function automatic logic [2:0] byte_count(input logic [2:0] ctrl);
      logic [2:0] n;
      n = 3'd0;
      case (ctrl)
         CTRL_B, CTRL_BU: n = 3'd1;
         CTRL_H, CTRL_HU: n = 3'd2;
         CTRL_W:          n = 3'd4;
         default:         n = 3'd0;
      endcase
      return n;
   endfunction

   // Unsigned size codes only make sense for loads.
   function automatic logic ctrl_legal(input logic [2:0] ctrl, input logic write);
      return (byte_count(ctrl) != 3'd0) && !(write && ctrl[2]);
   endfunction

endpackage

// File: rtl/lsu_byte_serial_if.sv
// CPU request/response and byte-wide memory port of the byte-serial LSU.
interface lsu_byte_serial_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_ctrl;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wbyte;
   logic [7:0]        mem_rbyte;

   // LSU side
   modport slave (
      input  req_valid, req_write, req_ctrl, req_addr, req_wdata, mem_rbyte,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wbyte
   );

   // CPU + memory side
   modport master (
      output req_valid, req_write, req_ctrl, req_addr, req_wdata, mem_rbyte,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wbyte
   );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of assembled little-endian load data by funct3 size code.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  ctrl,
   input  logic [31:0] data,
   output logic [31:0] ext_c
);

   always_comb begin
      ext_c = data;
      case (ctrl)
         CTRL_B:  ext_c = {{24{data[7]}}, data[7:0]};
         CTRL_H:  ext_c = {{16{data[15]}}, data[15:0]};
         CTRL_BU: ext_c = {24'h000000, data[7:0]};
         CTRL_HU: ext_c = {16'h0000, data[15:0]};
         default: ext_c = data;
      endcase
   end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store initiator: one request at a time, one memory byte per cycle.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module lsu_byte_serial
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic            clk,
   input  logic            rst,
   lsu_byte_serial_if.slave bus
);

   state_e            state;
   logic [2:0]        ctrl_q;
   logic [2:0]        n_q;
   logic [2:0]        cnt;
   logic              write_q;
   logic              err_q;
   logic [23:0]       wdata_q;
   logic [31:0]       rbuf;
   logic              req_ready_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [31:0]       resp_rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_we_q;
   logic [7:0]        mem_wbyte_q;

   logic [2:0]        n_c;
   logic              misalign_c;
   logic              reject_c;
   logic [31:0]       ext_c;
   logic              unused_c;

   assign n_c = byte_count(bus.req_ctrl);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign_c = ((n_c == 3'd2) && bus.req_addr[0]) ||
                       ((n_c == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`else
   assign misalign_c = 1'b0;
`endif

   assign reject_c = !ctrl_legal(bus.req_ctrl, bus.req_write) || misalign_c;
   assign unused_c = ^bus.req_addr[31:ADDR_W];

   lsu_load_extend u_extend (
      .ctrl  (ctrl_q),
      .data  (rbuf),
      .ext_c (ext_c)
   );

   // Request FSM; every port output comes straight from a register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         ctrl_q       <= 3'd0;
         n_q          <= 3'd0;
         cnt          <= 3'd0;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
         wdata_q      <= 24'h000000;
         rbuf         <= 32'h0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wbyte_q  <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: begin
               resp_valid_q <= 1'b0;
               if (bus.req_valid) begin
                  ctrl_q      <= bus.req_ctrl;
                  write_q     <= bus.req_write;
                  n_q         <= n_c;
                  cnt         <= 3'd0;
                  rbuf        <= 32'h0;
                  wdata_q     <= bus.req_wdata[31:8];
                  req_ready_q <= 1'b0;
                  if (reject_c) begin
                     err_q <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     err_q      <= 1'b0;
                     state      <= ST_ACCESS;
                     mem_addr_q <= bus.req_addr[ADDR_W-1:0];
                     mem_we_q   <= bus.req_write;
                     if (bus.req_write) begin
                        mem_wbyte_q <= bus.req_wdata[7:0];
                     end
                  end
               end
            end

            ST_ACCESS: begin
               if (!write_q) begin
                  rbuf[{cnt[1:0], 3'b000} +: 8] <= bus.mem_rbyte;
               end
               cnt <= cnt + 3'd1;
               if (cnt == n_q - 3'd1) begin
                  mem_we_q <= 1'b0;
                  state    <= ST_DONE;
               end else begin
                  // Address wraps naturally at the ADDR_W boundary.
                  mem_addr_q <= mem_addr_q + ADDR_W'(1);
                  if (write_q) begin
                     mem_wbyte_q <= wdata_q[7:0];
                     wdata_q     <= {8'h00, wdata_q[23:8]};
                  end
               end
            end

            ST_DONE: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= err_q;
               resp_rdata_q <= (err_q || write_q) ? 32'h0 : ext_c;
               req_ready_q  <= 1'b1;
               state        <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_wbyte  = mem_wbyte_q;

endmodule
